// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared opcodes and FSM state encodings for the shift sequencer
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_mux2.sv
// rtl/shift_mux2.sv - vector 2:1 mux primitive
module shift_mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - combinational single 2^k shift stage with selectable fill
module shift_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] k,
    input  logic               enable,
    input  logic               dir,
    input  logic               fill,
    output logic [WIDTH-1:0]   shifted
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   shl;
    logic [WIDTH-1:0]   shr;
    logic [WIDTH-1:0]   moved;

    // Both directions are formed in parallel; fill bits are OR-ed into the vacated positions.
    always_comb begin
        amt = SHAMT_W'(1) << k;
        shl = (value << amt) | (fill ? ~(ONES << amt) : '0);
        shr = (value >> amt) | (fill ? ~(ONES >> amt) : '0);
    end

    // dir=1 selects the right shift.
    shift_mux2 #(.WIDTH(WIDTH)) u_dir_mux (
        .a   (shl),
        .b   (shr),
        .sel (dir),
        .y   (moved)
    );

    // A clear shamt bit passes the value through unchanged.
    shift_mux2 #(.WIDTH(WIDTH)) u_en_mux (
        .a   (value),
        .b   (moved),
        .sel (enable),
        .y   (shifted)
    );

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle SLL/SRL/SRA engine, one 2^k stage per cycle
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               result_ready,
    output logic [WIDTH-1:0]   result,
    output logic               bad_op
);

    localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);

    state_t             state_q;
    state_t             state_d;
    logic [SHAMT_W-1:0] cnt_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [1:0]         op_q;
    logic               sign_q;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   result_q;

    logic               accept;
    logic               last_step;
    logic               stage_en;
    logic               stage_dir;
    logic               stage_fill;
    logic [WIDTH-1:0]   stage_out;

    assign accept    = (state_q == ST_IDLE) && ctrl_shift;
    assign last_step = (state_q == ST_SHIFT) && (cnt_q == LAST_STAGE);

    // Select the latched shamt bit for the current stage; reserved op never shifts.
    always_comb begin
        stage_en = 1'b0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (cnt_q == SHAMT_W'(i)) begin
                stage_en = shamt_q[i];
            end
        end
        if (op_q == OP_RSV) begin
            stage_en = 1'b0;
        end
        stage_dir  = (op_q != OP_SLL);
        // Latched sign, not the working MSB, so SLL/SRL always zero-fill.
        stage_fill = (op_q == OP_SRA) && sign_q;
    end

    shift_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_stage (
        .value   (work_q),
        .k       (cnt_q),
        .enable  (stage_en),
        .dir     (stage_dir),
        .fill    (stage_fill),
        .shifted (stage_out)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SHIFT (SHAMT_W cycles) -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (last_step) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Operand capture, stage walk and result update; the final stage writes result directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            shamt_q  <= '0;
            op_q     <= OP_SLL;
            sign_q   <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                cnt_q   <= '0;
                shamt_q <= shamt;
                op_q    <= op;
                sign_q  <= data_in[WIDTH-1];
                work_q  <= data_in;
            end else if (state_q == ST_SHIFT) begin
                work_q <= stage_out;
                cnt_q  <= cnt_q + SHAMT_W'(1);
                if (last_step) begin
                    result_q <= stage_out;
                end
            end
        end
    end

    assign busy         = (state_q == ST_SHIFT);
    assign result_ready = (state_q == ST_DONE);
    assign bad_op       = (state_q == ST_DONE) && (op_q == OP_RSV);
    assign result       = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int LAT     = SHAMT_W + 1;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               ctrl_shift = 1'b0;
    logic [1:0]         op = 2'b00;
    logic [WIDTH-1:0]   data_in = '0;
    logic [SHAMT_W-1:0] shamt = '0;
    logic               busy;
    logic               result_ready;
    logic [WIDTH-1:0]   result;
    logic               bad_op;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_result = '0;

    always #5 clock = ~clock;

    shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .ctrl_shift   (ctrl_shift),
        .op           (op),
        .data_in      (data_in),
        .shamt        (shamt),
        .busy         (busy),
        .result_ready (result_ready),
        .result       (result),
        .bad_op       (bad_op)
    );

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_shift(input string tag, input logic [31:0] d, input logic [4:0] s,
                             input logic [1:0] o, input logic [31:0] exp, input bit noise);
        int cyc;
        bit seen;
        seen = 1'b0;
        ctrl_shift = 1'b1;
        data_in    = d;
        shamt      = s;
        op         = o;
        @(posedge clock);
        for (cyc = 1; cyc <= LAT + 4; cyc++) begin
            @(negedge clock);
            if (result_ready) begin
                seen = 1'b1;
                break;
            end
            check_bit({tag, "/busy"}, busy, 1'b1);
            check({tag, "/held"}, result, last_result);
            if (noise) begin
                ctrl_shift = 1'b1;
                data_in    = $urandom;
                shamt      = 5'($urandom);
                op         = 2'($urandom);
            end else begin
                ctrl_shift = 1'b0;
            end
        end
        check({tag, "/latency"}, seen ? 32'(cyc) : 32'd0, 32'(LAT));
        check({tag, "/result"}, result, exp);
        check_bit({tag, "/bad_op"}, bad_op, o == 2'b11);
        check_bit({tag, "/busy_done"}, busy, 1'b0);
        last_result = exp;
        @(negedge clock);
        check_bit({tag, "/pulse"}, result_ready, 1'b0);
        check_bit({tag, "/idle"}, busy, 1'b0);
        check_bit({tag, "/bad_op_low"}, bad_op, 1'b0);
        check({tag, "/kept"}, result, exp);
        ctrl_shift = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [4:0]  rs;
        logic [1:0]  ro;

        repeat (2) @(negedge clock);
        check_bit("rst/busy", busy, 1'b0);
        check_bit("rst/ready", result_ready, 1'b0);
        check_bit("rst/bad_op", bad_op, 1'b0);
        check("rst/result", result, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        check_bit("rst/stay_idle", busy, 1'b0);

        run_shift("sra4",    32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0);
        run_shift("srl4",    32'hF000_000F, 5'd4,  2'b01, 32'h0F00_0000, 1'b0);
        run_shift("sll31",   32'hF000_000F, 5'd31, 2'b00, 32'h8000_0000, 1'b0);
        run_shift("sra0",    32'h7FFF_FFFF, 5'd0,  2'b10, 32'h7FFF_FFFF, 1'b0);
        run_shift("sra31",   32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b0);
        run_shift("sll_neg", 32'h8000_0001, 5'd1,  2'b00, 32'h0000_0002, 1'b0);
        run_shift("noise",   32'h0000_1234, 5'd8,  2'b00, 32'h0012_3400, 1'b1);
        run_shift("b2b",     32'h8765_4321, 5'd12, 2'b10, 32'hFFF8_7654, 1'b0);
        run_shift("rsv",     32'hDEAD_BEEF, 5'd7,  2'b11, 32'hDEAD_BEEF, 1'b0);

        ctrl_shift = 1'b1;
        data_in    = 32'hFFFF_0000;
        shamt      = 5'd3;
        op         = 2'b01;
        @(posedge clock);
        ctrl_shift = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_bit("abort/busy", busy, 1'b0);
        check_bit("abort/ready", result_ready, 1'b0);
        check("abort/result", result, 32'h0);
        reset = 1'b0;
        last_result = '0;
        @(negedge clock);
        check_bit("abort/idle", busy, 1'b0);
        run_shift("after_abort", 32'hFFFF_0000, 5'd3, 2'b01, 32'h1FFF_E000, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rd = $urandom;
            rs = 5'($urandom);
            ro = 2'($urandom);
            run_shift("rand", rd, rs, ro, model(rd, rs, ro), (i % 4) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
